// File: rtl/display_bcd_formatter_pkg.sv
// Shared encodings and field layout for the BCD display formatter.
// Also holds the helper that builds the display word.
package display_bcd_formatter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   localparam logic [3:0] SIGN_NEG = 4'hF;
   localparam logic [3:0] SIGN_POS = 4'h0;

   localparam int BCD_DIGITS = 10;
   localparam int BCD_W      = 4 * BCD_DIGITS;
   localparam int TAG_LSB    = 48;
   localparam int SIGN_LSB   = 40;
   localparam int CNT_W      = 6;

   // Display word: {tag, 4'h0, sign, bcd9..bcd0}
   function automatic logic [63:0] pack_word(input logic [15:0] tag_f,
                                             input logic [3:0] sign_f,
                                             input logic [BCD_W-1:0] bcd_f);
      logic [63:0] w;
      w = '0;
      w[TAG_LSB +: 16]  = tag_f;
      w[SIGN_LSB +: 4]  = sign_f;
      w[BCD_W-1:0]      = bcd_f;
      return w;
   endfunction

endpackage

// File: rtl/display_bcd_formatter_add3.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
// Instantiated once per digit by the formatter top.
module bcd_add3_digit (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= 4'd5) digit_out = digit_in + 4'd3;
   end

endmodule

// File: rtl/display_bcd_formatter.sv
// Binary to 10-digit BCD converter (sequential double-dabble) feeding the
// 16-digit dot-matrix driver; data_out only changes on a finished conversion.
//
// state     | meaning
// ST_IDLE   | waiting for start; captures value/tag on start
// ST_SHIFT  | WIDTH add-3/shift steps
// ST_FINISH | publish data_out, pulse done
module display_bcd_formatter
   import display_bcd_formatter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clock_27mhz,
   input  logic             reset_b,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   input  logic [15:0]      tag,
   output logic             busy,
   output logic             done,
   output logic [63:0]      data_out
);

   logic [1:0]       state;
   logic [WIDTH-1:0] shift_q;
   logic [BCD_W-1:0] bcd_q;
   logic [BCD_W-1:0] bcd_adj;
   logic [CNT_W-1:0] cnt_q;
   logic [15:0]      tag_q;
   logic [3:0]       sign_q;
   logic             neg;
   logic [WIDTH:0]   val_ext;
   logic [WIDTH:0]   mag;

   // Negate in WIDTH+1 bits so the most-negative input keeps its full magnitude
   always_comb begin
      neg     = SIGNED && value[WIDTH-1];
      val_ext = {neg, value};
      mag     = neg ? (~val_ext + (WIDTH+1)'(1)) : val_ext;
   end

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
      bcd_add3_digit u_add3 (
         .digit_in  (bcd_q[4*g +: 4]),
         .digit_out (bcd_adj[4*g +: 4])
      );
   end

   always_ff @(posedge clock_27mhz or negedge reset_b) begin
      if (!reset_b) begin
         state    <= ST_IDLE;
         shift_q  <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         tag_q    <= '0;
         sign_q   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  shift_q <= mag[WIDTH-1:0];
                  bcd_q   <= '0;
                  cnt_q   <= CNT_W'(WIDTH-1);
                  tag_q   <= tag;
                  sign_q  <= neg ? SIGN_NEG : SIGN_POS;
                  busy    <= 1'b1;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
               shift_q <= shift_q << 1;
               if (cnt_q == '0) state <= ST_FINISH;
               else             cnt_q <= cnt_q - CNT_W'(1);
            end
            ST_FINISH: begin
               data_out <= pack_word(tag_q, sign_q, bcd_q);
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
